// File: rtl/fm_sb_pkg.sv
// rtl/fm_sb_pkg.sv - shared types, widths and helpers for the fast-monitoring spy buffers
//
// Purpose : common definitions for the spy-buffer writer and its read pipeline.
// Contents: monitored-width limits, mode and state enums, and the per-buffer
//           address-width helper derived from the AXI byte window of one buffer.
package fm_sb_pkg;

    localparam int MON_DW_MAX        = 256;
    localparam int PB_MODE_WIDTH     = 2;
    localparam int SB_STATE_WIDTH    = 3;
    // Byte-address window one spy buffer occupies on the AXI read-out side.
    localparam int AXI_SB_ADDR_WIDTH = 15;

    typedef enum logic [PB_MODE_WIDTH-1:0] {
        SB_MODE_CIRCULAR = 2'd0,
        SB_MODE_ONESHOT  = 2'd1,
        SB_MODE_HOLD     = 2'd2,
        SB_MODE_PLAYBACK = 2'd3
    } sb_mode_t;

    typedef enum logic [SB_STATE_WIDTH-1:0] {
        SB_IDLE      = 3'd0,
        SB_CAPTURE   = 3'd1,
        SB_POST_TRIG = 3'd2,
        SB_FROZEN    = 3'd3,
        SB_HOLD      = 3'd4,
        SB_PLAYBACK  = 3'd5
    } sb_state_t;

    // Word-address width of a buffer: the AXI byte window minus the byte
    // offset bits of one monitored word (256-bit words give 10 address bits).
    function automatic int sb_addr_width(input int dw);
        return AXI_SB_ADDR_WIDTH - int'($clog2(dw / 8));
    endfunction

endpackage

// File: rtl/fm_sb_rd_pipe.sv
// rtl/fm_sb_rd_pipe.sv - read-latency valid alignment pipeline for spy-buffer playback
//
// Purpose : delays the "address issued" flag by RD_LAT cycles so the valid
//           lines up with memory read data; data is forced to 0 when not valid.
// Ports   : clk_i, rst_ni    clock, asynchronous active-low reset
//           flush_i          clears every in-flight valid (re-arm)
//           issue_i          a read address is being presented this cycle
//           rdata_i          memory read data
//           vld_o, data_o    aligned playback valid and data
module fm_sb_rd_pipe
    import fm_sb_pkg::*;
#(
    parameter int SB_DW  = MON_DW_MAX,
    parameter int RD_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             issue_i,
    input  logic [SB_DW-1:0] rdata_i,
    output logic             vld_o,
    output logic [SB_DW-1:0] data_o
);

    logic [RD_LAT-1:0] vld_sr_q;
    logic [RD_LAT-1:0] vld_sr_d;

    always_comb begin
        vld_sr_d    = '0;
        vld_sr_d[0] = issue_i & ~flush_i;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1] & ~flush_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q <= vld_sr_d;
        end
    end

    assign vld_o  = vld_sr_q[RD_LAT-1];
    assign data_o = vld_o ? rdata_i : '0;

endmodule

// File: rtl/fm_sb_writer.sv
// rtl/fm_sb_writer.sv - write-side capture / playback controller for one spy buffer
//
// Purpose : captures the monitored stream into the spy-buffer memory in circular
//           or one-shot mode with trigger freeze and post-trigger count, holds the
//           buffer for read-out, or plays the buffer back as a stream.
// Ports   : spy_clock, spy_reset_n      clock, asynchronous active-low reset
//           fm_data, fm_vld             monitored stream in
//           pb_mode, arm                mode select (sampled on arm), start pulse
//           freeze_req, post_trig_cnt   trigger pulse and words still written after it
//           mem_we/addr/wdata, mem_rdata  spy-buffer memory port
//           pb_data, pb_vld             playback stream out
//           sb_state, frozen, wrapped, trig_addr, word_cnt  status
module fm_sb_writer
    import fm_sb_pkg::*;
#(
    parameter int SB_DW  = MON_DW_MAX,
    parameter int ADDR_W = sb_addr_width(MON_DW_MAX),
    parameter int RD_LAT = 2
) (
    input  logic                       spy_clock,
    input  logic                       spy_reset_n,
    input  logic [SB_DW-1:0]           fm_data,
    input  logic                       fm_vld,
    input  logic [PB_MODE_WIDTH-1:0]   pb_mode,
    input  logic                       arm,
    input  logic                       freeze_req,
    input  logic [ADDR_W-1:0]          post_trig_cnt,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [SB_DW-1:0]           mem_wdata,
    input  logic [SB_DW-1:0]           mem_rdata,
    output logic [SB_DW-1:0]           pb_data,
    output logic                       pb_vld,
    output logic [SB_STATE_WIDTH-1:0]  sb_state,
    output logic                       frozen,
    output logic                       wrapped,
    output logic [ADDR_W-1:0]          trig_addr,
    output logic [ADDR_W:0]            word_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    sb_state_t          state_q, state_d;
    sb_mode_t           mode_q, mode_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  ptc_q, ptc_d;
    logic [ADDR_W-1:0]  trig_addr_q, trig_addr_d;
    logic [ADDR_W:0]    word_cnt_q, word_cnt_d;
    logic               wrapped_q, wrapped_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [SB_DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic               capturing;
    logic               wr_accept;
    logic               at_end;
    logic               oneshot_end;
    logic               trig_now;

    // arm takes priority over everything, so a word arriving in the arm cycle
    // is dropped rather than written at the stale pointer.
    assign capturing   = (state_q == SB_CAPTURE) || (state_q == SB_POST_TRIG);
    assign wr_accept   = fm_vld && capturing && !arm;
    assign at_end      = (wr_ptr_q == ADDR_MAX);
    assign oneshot_end = wr_accept && at_end && (mode_q == SB_MODE_ONESHOT);
    assign trig_now    = freeze_req && !arm && (state_q == SB_CAPTURE);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge spy_clock or negedge spy_reset_n) begin
        if (!spy_reset_n) begin
            state_q <= SB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (arm) begin
            unique case (sb_mode_t'(pb_mode))
                SB_MODE_CIRCULAR,
                SB_MODE_ONESHOT:  state_d = SB_CAPTURE;
                SB_MODE_HOLD:     state_d = SB_HOLD;
                SB_MODE_PLAYBACK: state_d = SB_PLAYBACK;
                default:          state_d = SB_IDLE;
            endcase
        end else begin
            case (state_q)
                SB_CAPTURE: begin
                    if (oneshot_end) begin
                        state_d = SB_FROZEN;
                    end else if (trig_now) begin
                        state_d = (post_trig_cnt == '0) ? SB_FROZEN : SB_POST_TRIG;
                    end
                end
                SB_POST_TRIG: begin
                    // The write that takes the counter from 1 to 0 is the last one.
                    if (oneshot_end || (wr_accept && (ptc_q == PTC_ONE))) begin
                        state_d = SB_FROZEN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- datapath next
    always_comb begin
        mode_d      = mode_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ptc_d       = ptc_q;
        trig_addr_d = trig_addr_q;
        word_cnt_d  = word_cnt_q;
        wrapped_d   = wrapped_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (arm) begin
            mode_d      = sb_mode_t'(pb_mode);
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ptc_d       = '0;
            trig_addr_d = '0;
            word_cnt_d  = '0;
            wrapped_d   = 1'b0;
        end else begin
            if (wr_accept) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_ptr_q;
                mem_wdata_d = fm_data;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                // One-shot freezes on the last address instead of wrapping.
                if (at_end && (mode_q != SB_MODE_ONESHOT)) begin
                    wrapped_d = 1'b1;
                end
                if (!word_cnt_q[ADDR_W]) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
                if (state_q == SB_POST_TRIG) begin
                    ptc_d = ptc_q - 1'b1;
                end
            end
            // The trigger position points past a word written in the same cycle.
            if (trig_now) begin
                trig_addr_d = wr_accept ? (wr_ptr_q + 1'b1) : wr_ptr_q;
                ptc_d       = post_trig_cnt;
            end
            if (state_q == SB_PLAYBACK) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge spy_clock or negedge spy_reset_n) begin
        if (!spy_reset_n) begin
            mode_q      <= SB_MODE_CIRCULAR;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ptc_q       <= '0;
            trig_addr_q <= '0;
            word_cnt_q  <= '0;
            wrapped_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mode_q      <= mode_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ptc_q       <= ptc_d;
            trig_addr_q <= trig_addr_d;
            word_cnt_q  <= word_cnt_d;
            wrapped_q   <= wrapped_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // ---------------------------------------------------------------- playback pipe
    fm_sb_rd_pipe #(
        .SB_DW  (SB_DW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i   (spy_clock),
        .rst_ni  (spy_reset_n),
        .flush_i (arm),
        .issue_i (state_q == SB_PLAYBACK),
        .rdata_i (mem_rdata),
        .vld_o   (pb_vld),
        .data_o  (pb_data)
    );

    // ---------------------------------------------------------------- outputs
    // In playback the read pointer drives the address directly so the read
    // latency counts from the first PLAYBACK cycle.
    always_comb begin
        mem_we    = mem_we_q;
        mem_addr  = (state_q == SB_PLAYBACK) ? rd_ptr_q : mem_addr_q;
        mem_wdata = mem_wdata_q;
        sb_state  = state_q;
        frozen    = (state_q == SB_FROZEN) || (state_q == SB_HOLD);
        wrapped   = wrapped_q;
        trig_addr = trig_addr_q;
        word_cnt  = (state_q == SB_HOLD) ? '0 : word_cnt_q;
    end

endmodule

// File: tb/tb_fm_sb_writer.sv
// tb/tb_fm_sb_writer.sv - directed self-checking bench for fm_sb_writer
module tb_fm_sb_writer;

    localparam int SB_DW  = 16;
    localparam int ADDR_W = 4;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              spy_clock = 1'b0;
    logic              spy_reset_n = 1'b0;
    logic [SB_DW-1:0]  fm_data = '0;
    logic              fm_vld = 1'b0;
    logic [1:0]        pb_mode = 2'd0;
    logic              arm = 1'b0;
    logic              freeze_req = 1'b0;
    logic [ADDR_W-1:0] post_trig_cnt = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [SB_DW-1:0]  mem_wdata;
    logic [SB_DW-1:0]  mem_rdata;
    logic [SB_DW-1:0]  pb_data;
    logic              pb_vld;
    logic [2:0]        sb_state;
    logic              frozen;
    logic              wrapped;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W:0]   word_cnt;

    fm_sb_writer #(
        .SB_DW  (SB_DW),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .spy_clock     (spy_clock),
        .spy_reset_n   (spy_reset_n),
        .fm_data       (fm_data),
        .fm_vld        (fm_vld),
        .pb_mode       (pb_mode),
        .arm           (arm),
        .freeze_req    (freeze_req),
        .post_trig_cnt (post_trig_cnt),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .pb_data       (pb_data),
        .pb_vld        (pb_vld),
        .sb_state      (sb_state),
        .frozen        (frozen),
        .wrapped       (wrapped),
        .trig_addr     (trig_addr),
        .word_cnt      (word_cnt)
    );

    always #5 spy_clock = ~spy_clock;

    // Read-only memory preloaded mem[k]=k with a two-stage read pipeline.
    logic [SB_DW-1:0] mem [DEPTH];
    logic [SB_DW-1:0] rd1, rd2;
    initial for (int k = 0; k < DEPTH; k++) mem[k] = SB_DW'(k);
    always @(posedge spy_clock) begin
        rd1 <= mem[mem_addr];
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    // Log of every write the DUT presents.
    int wlog_addr [$];
    int wlog_data [$];
    always @(posedge spy_clock) begin
        if (mem_we === 1'b1) begin
            wlog_addr.push_back(int'(mem_addr));
            wlog_data.push_back(int'(mem_wdata));
        end
    end

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge spy_clock);
        #1;
    endtask

    task automatic do_arm(input logic [1:0] mode);
        pb_mode = mode;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(sb_state), 0);
        check({tag, "_we"}, 32'(mem_we), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_pbvld"}, 32'(pb_vld), 0);
        check({tag, "_pbdata"}, 32'(pb_data), 0);
        check({tag, "_frozen"}, 32'(frozen), 0);
        check({tag, "_wrapped"}, 32'(wrapped), 0);
        check({tag, "_trig"}, 32'(trig_addr), 0);
        check({tag, "_wcnt"}, 32'(word_cnt), 0);
    endtask

    initial begin
        // ---------------- reset state
        #2;
        check_all_zero("rst");
        tick();
        spy_reset_n = 1'b1;
        tick();
        check("idle_state", 32'(sb_state), 0);

        // ---------------- circular, 20 words
        clear_log();
        do_arm(2'd0);
        check("circ_state", 32'(sb_state), 1);
        for (int i = 0; i < 20; i++) begin
            fm_vld = 1'b1;
            fm_data = SB_DW'(i);
            tick();
            if (i == 14) check("circ_wrap_pre", 32'(wrapped), 0);
            if (i == 15) check("circ_wrap_post", 32'(wrapped), 1);
        end
        fm_vld = 1'b0;
        tick();
        tick();
        check("circ_nwr", 32'(wlog_addr.size()), 20);
        for (int i = 0; i < 20 && i < wlog_addr.size(); i++) begin
            check($sformatf("circ_addr%0d", i), 32'(wlog_addr[i]), 32'(i % 16));
            check($sformatf("circ_data%0d", i), 32'(wlog_data[i]), 32'(i));
        end
        check("circ_wcnt", 32'(word_cnt), 16);
        check("circ_wrapped", 32'(wrapped), 1);

        // ---------------- one-shot, 20 words
        clear_log();
        do_arm(2'd1);
        check("os_wcnt_clr", 32'(word_cnt), 0);
        check("os_wrap_clr", 32'(wrapped), 0);
        for (int i = 0; i < 20; i++) begin
            fm_vld = 1'b1;
            fm_data = SB_DW'(i);
            tick();
            if (i == 14) check("os_state_pre", 32'(sb_state), 1);
            if (i == 15) begin
                check("os_state_frz", 32'(sb_state), 3);
                check("os_frozen", 32'(frozen), 1);
            end
            if (i == 17) check("os_we_off", 32'(mem_we), 0);
        end
        fm_vld = 1'b0;
        tick();
        check("os_nwr", 32'(wlog_addr.size()), 16);
        if (wlog_addr.size() > 0)
            check("os_last_addr", 32'(wlog_addr[wlog_addr.size()-1]), 15);
        check("os_wcnt", 32'(word_cnt), 16);

        // ---------------- circular freeze with post-trigger count 3
        clear_log();
        do_arm(2'd0);
        post_trig_cnt = 4'd3;
        for (int i = 0; i < 12; i++) begin
            fm_vld = 1'b1;
            fm_data = SB_DW'(8'h40 + i);
            freeze_req = (i == 4);
            tick();
            if (i == 4) check("pt_state", 32'(sb_state), 2);
            if (i == 6) check("pt_state_mid", 32'(sb_state), 2);
            if (i == 7) check("pt_state_frz", 32'(sb_state), 3);
        end
        freeze_req = 1'b0;
        fm_vld = 1'b0;
        tick();
        check("pt_trig", 32'(trig_addr), 5);
        check("pt_nwr", 32'(wlog_addr.size()), 8);
        if (wlog_addr.size() > 0)
            check("pt_last_addr", 32'(wlog_addr[wlog_addr.size()-1]), 7);
        check("pt_wcnt", 32'(word_cnt), 8);

        // ---------------- arm and freeze in the same cycle: arm wins
        post_trig_cnt = '0;
        freeze_req = 1'b1;
        do_arm(2'd0);
        freeze_req = 1'b0;
        check("aw_state", 32'(sb_state), 1);
        check("aw_trig", 32'(trig_addr), 0);
        check("aw_wcnt", 32'(word_cnt), 0);
        fm_vld = 1'b1;
        fm_data = 16'h00AA;
        tick();
        check("aw_we0", 32'(mem_we), 1);
        check("aw_addr0", 32'(mem_addr), 0);
        fm_data = 16'h00BB;
        freeze_req = 1'b1;
        tick();
        freeze_req = 1'b0;
        check("lf_state", 32'(sb_state), 3);
        check("lf_we", 32'(mem_we), 1);
        check("lf_addr", 32'(mem_addr), 1);
        check("lf_wdata", 32'(mem_wdata), 32'h00BB);
        check("lf_trig", 32'(trig_addr), 2);
        tick();
        check("lf_we_off", 32'(mem_we), 0);
        check("lf_frozen", 32'(frozen), 1);
        fm_vld = 1'b0;

        // ---------------- playback
        do_arm(2'd3);
        check("pb_state", 32'(sb_state), 5);
        check("pb_frozen", 32'(frozen), 0);
        check("pb_addr0", 32'(mem_addr), 0);
        check("pb_vld_a1", 32'(pb_vld), 0);
        tick();
        check("pb_vld_a2", 32'(pb_vld), 0);
        check("pb_data_a2", 32'(pb_data), 0);
        tick();
        check("pb_vld_a3", 32'(pb_vld), 1);
        check("pb_data0", 32'(pb_data), 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("pb_vld%0d", k), 32'(pb_vld), 1);
            check($sformatf("pb_data%0d", k), 32'(pb_data), 32'(k % 16));
        end
        // leave playback into HOLD: pipeline flushed on the next cycle
        do_arm(2'd2);
        check("hold_pbvld", 32'(pb_vld), 0);
        check("hold_pbdata", 32'(pb_data), 0);
        check("hold_state", 32'(sb_state), 4);
        check("hold_frozen", 32'(frozen), 1);
        check("hold_wcnt", 32'(word_cnt), 0);
        fm_vld = 1'b1;
        tick();
        check("hold_we", 32'(mem_we), 0);
        fm_vld = 1'b0;

        // ---------------- reset mid-POST_TRIG
        do_arm(2'd0);
        fm_vld = 1'b1;
        tick();
        tick();
        post_trig_cnt = 4'd10;
        freeze_req = 1'b1;
        tick();
        freeze_req = 1'b0;
        tick();
        check("rpt_state_pre", 32'(sb_state), 2);
        #2 spy_reset_n = 1'b0;
        #1 check_all_zero("rpt");
        #2 spy_reset_n = 1'b1;
        clear_log();
        tick();
        tick();
        tick();
        check("rpt_idle", 32'(sb_state), 0);
        check("rpt_nwr", 32'(wlog_addr.size()), 0);
        fm_vld = 1'b0;

        // ---------------- reset mid-PLAYBACK
        do_arm(2'd3);
        tick();
        tick();
        tick();
        check("rpb_vld_pre", 32'(pb_vld), 1);
        #2 spy_reset_n = 1'b0;
        #1 check_all_zero("rpb");
        #2 spy_reset_n = 1'b1;
        tick();
        tick();
        check("rpb_idle", 32'(sb_state), 0);
        check("rpb_pbvld", 32'(pb_vld), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fm_sb_writer.md
Name: fm_sb_writer

Overview:
- Write-side controller for one fast-monitoring spy buffer; sits directly upstream of the spy-buffer memory described by the fm_sb_pkg parameter set.
- Captures the fm_rt stream (fm_data/fm_vld) from a tapped user-logic bus into the buffer, in circular or one-shot mode, with freeze and post-trigger count.
- In playback mode it reads the buffer back and drives an fm_rt-style stream for injection.
- One instance per mapped spy buffer (sb_mapped_n instances).

Parameters:
- SB_DW, 256 (mon_dw_max): monitored data width; per-instance value taken from sb_dw[i].
- ADDR_W, 10: spy-buffer memory address width; depth = 2**ADDR_W.
- RD_LAT, 2: memory read latency in cycles, 1..4.

Ports:
- spy_clock  in  1  single clock for all logic.
- spy_reset_n  in  1  asynchronous, active-low reset.
- fm_data  in  SB_DW  monitored data.
- fm_vld  in  1  monitored data valid.
- pb_mode  in  2  mode: 00 circular, 01 one-shot, 10 hold, 11 playback; sampled only on arm.
- arm  in  1  single-cycle start/restart pulse.
- freeze_req  in  1  single-cycle trigger pulse.
- post_trig_cnt  in  ADDR_W  writes still performed after freeze_req; sampled on freeze_req.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory write/read address.
- mem_wdata  out  SB_DW  memory write data.
- mem_rdata  in  SB_DW  memory read data, valid RD_LAT cycles after the address.
- pb_data  out  SB_DW  playback data.
- pb_vld  out  1  playback valid.
- sb_state  out  3  current FSM state encoding.
- frozen  out  1  buffer contents stable and readable over AXI.
- wrapped  out  1  write pointer has wrapped at least once since arm.
- trig_addr  out  ADDR_W  wr_ptr value at freeze_req.
- word_cnt  out  ADDR_W+1  valid words in buffer; saturates at 2**ADDR_W.

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE.
  - All outputs 0; wr_ptr, rd_ptr, counters and read-valid pipeline cleared.
  - Reset mid-capture or mid-playback aborts immediately; no partial write completes.
- FSM states: IDLE=0, CAPTURE=1, POST_TRIG=2, FROZEN=3, HOLD=4, PLAYBACK=5.
- arm, accepted in any state:
  - Clears wr_ptr, rd_ptr, wrapped, word_cnt, trig_addr and the read-valid pipeline.
  - Latches pb_mode and moves to: CAPTURE for 00 or 01, HOLD for 10, PLAYBACK for 11.
- Writes (CAPTURE/POST_TRIG), registered, 1-cycle latency:
  - fm_vld at cycle N gives mem_we=1, mem_addr=wr_ptr, mem_wdata=fm_data at N+1.
  - wr_ptr increments modulo 2**ADDR_W.
  - Write to address 2**ADDR_W-1 sets wrapped sticky.
  - word_cnt increments and saturates at 2**ADDR_W.
- One-shot (01): the write to address 2**ADDR_W-1 moves to FROZEN; no wrap occurs.
- freeze_req in CAPTURE:
  - trig_addr <= wr_ptr, including any increment from a same-cycle fm_vld.
  - post_trig_cnt=0: go to FROZEN next cycle; a same-cycle fm_vld word is still written.
  - Otherwise load the post-trigger counter and go to POST_TRIG.
- POST_TRIG:
  - Each write decrements the counter.
  - The write that reaches 0 moves to FROZEN.
  - One-shot end-of-buffer also moves to FROZEN, whichever comes first.
- freeze_req outside CAPTURE is ignored; arm and freeze_req in the same cycle: arm wins.
- FROZEN/HOLD:
  - mem_we held 0; frozen=1.
  - HOLD writes nothing and reports word_cnt=0.
- PLAYBACK:
  - Every cycle: mem_addr=rd_ptr, rd_ptr increments modulo 2**ADDR_W.
  - A RD_LAT-deep valid shift register aligns pb_vld with mem_rdata.
  - pb_data=mem_rdata when pb_vld, else 0.
  - Free-running; no backpressure.
  - Leaving PLAYBACK via arm flushes the pipeline: pb_vld=0 from the next cycle.
- frozen=0 in every state except FROZEN and HOLD.

Decomposition:
- fm_sb_pkg gains:
  - sb_mode_t enum (circular/one-shot/hold/playback), matching pb_mode_width=2.
  - sb_state_t enum for the six states.
  - sb_addr_width[i] helper derived from axi_sb_addr_width.
- fm_rt is reused for the input and playback streams.
- Natural sub-module: fm_sb_rd_pipe, the RD_LAT valid/data alignment pipeline used in PLAYBACK.

Test Plan:
- ADDR_W=4, circular, 20 consecutive fm_vld with data=index → mem_we pulses at addresses 0..15 then 0..3; wrapped=1 after the 16th write; word_cnt=16.
- ADDR_W=4, one-shot, 20 fm_vld → exactly 16 writes; state FROZEN the cycle after the write to 15; frozen=1; writes for words 16..19 absent.
- Circular, freeze_req while wr_ptr=5 with post_trig_cnt=3 and continuous fm_vld → trig_addr=5; last write at address 7; FROZEN next cycle.
- freeze_req with post_trig_cnt=0 and arm in the same cycle → arm wins, state CAPTURE, wr_ptr=0; a later lone freeze_req → FROZEN next cycle.
- Playback, RD_LAT=2, memory preloaded mem[k]=k → pb_vld first high 2 cycles after arm+1; pb_data sequence 0,1,2,…,15,0 contiguous.
- spy_reset_n asserted mid-POST_TRIG and mid-PLAYBACK → all outputs 0 asynchronously; IDLE after release; no mem_we until arm.
